sr_debounce_cmd: RTL

- Upstream command stage for the SR flip-flop.
- Takes two raw, asynchronous, bouncy push-button inputs (set and reset) and synchronises and debounces each one.
- Emits clean single-cycle S/R command pulses for the flip-flop's S and R inputs.
- Suppresses the forbidden S=R=1 combination by detecting simultaneous commands and flagging them instead of forwarding them.

---
 rtl/sr_debounce_cmd.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sr_debounce_cmd.sv
// rtl/sr_debounce_cmd.sv - synchronise, debounce and edge-detect two buttons into S/R command pulses

// One button channel: two-flop synchroniser, consecutive-sample debounce
// counter and rising-edge detector on the debounced level.
module sr_debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Raw,
    output logic o_Lvl,
    output logic o_Rise
);

    // Last count value before the level is allowed to flip.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lvl_q;
    logic             lvl_d;
    logic             lvl_prev_q;

    // Two-flop synchroniser; the raw button is asynchronous to i_Clk.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_Raw;
            sync2_q <= sync1_q;
        end
    end

    // Qualification: the synchronised sample must disagree with the level
    // for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample restarts it.
    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (sync2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            lvl_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter, debounced level and its one-cycle delayed copy.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt_q      <= '0;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
        end
    end

    // Only presses (0->1 of the debounced level) generate a command.
    assign o_Lvl  = lvl_q;
    assign o_Rise = lvl_q & ~lvl_prev_q;

endmodule

// Top: two independent channels feeding a registered command stage that
// never forwards S and R together and flags simultaneous presses instead.
module sr_debounce_cmd #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Set_Btn,
    input  logic i_Rst_Btn,
    output logic o_S,
    output logic o_R,
    output logic o_Set_Lvl,
    output logic o_Rst_Lvl,
    output logic o_Conflict
);

    logic rise_set;
    logic rise_rst;
    logic s_q;
    logic s_d;
    logic r_q;
    logic r_d;
    logic conflict_q;
    logic conflict_d;

    sr_debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_set_chan (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_Raw (i_Set_Btn),
        .o_Lvl (o_Set_Lvl),
        .o_Rise(rise_set)
    );

    sr_debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_rst_chan (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_Raw (i_Rst_Btn),
        .o_Lvl (o_Rst_Lvl),
        .o_Rise(rise_rst)
    );

    // Command decode: a lone rise becomes a command, a coincident pair
    // becomes a conflict so the flip-flop never sees S=R=1.
    always_comb begin
        s_d        = rise_set & ~rise_rst;
        r_d        = rise_rst & ~rise_set;
        conflict_d = rise_set & rise_rst;
    end

    // Registered command outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign o_S        = s_q;
    assign o_R        = r_q;
    assign o_Conflict = conflict_q;

endmodule
